// File: rtl/tilt_cursor_mover_pkg.sv
// Shared tilt-code constants, FSM encoding and the per-axis normaliser.
// Pure declarations; no logic, latency or backpressure of its own.
package tilt_pkg;

  localparam logic [1:0] TILT_NONE = 2'b00;
  localparam logic [1:0] TILT_POS  = 2'b10;
  localparam logic [1:0] TILT_NEG  = 2'b11;

  localparam int GRID_DEF = 8;

  typedef enum logic {
    HOLD = 1'b0,
    MOVE = 1'b1
  } state_t;

  // Returns {enable, negative}; the sign is dropped when the axis is level.
  function automatic logic [1:0] norm_axis(input logic [1:0] code);
    logic en;
    logic neg;
    en  = (code == TILT_POS) || (code == TILT_NEG);
    neg = (code == TILT_NEG);
    return {en, neg};
  endfunction

endpackage

// File: rtl/tilt_cursor_mover_if.sv
// Tilt inputs and cursor/matrix outputs of the cursor mover as one bundle.
// slave = the mover itself, master = whoever drives tilt codes and watches the matrix.
interface tilt_cursor_mover_if #(
  parameter int GRID = 8,
  parameter int PW   = 3
);
  logic [1:0]      iDATA_X;
  logic [1:0]      iDATA_Y;
  logic            iDATA_STOP;
  logic            iCENTER;
  logic [PW-1:0]   oPOS_X;
  logic [PW-1:0]   oPOS_Y;
  logic            oMOVING;
  logic            oHIT;
  logic [GRID-1:0] oROW;
  logic [GRID-1:0] oCOL;

  modport slave (
    input  iDATA_X, iDATA_Y, iDATA_STOP, iCENTER,
    output oPOS_X, oPOS_Y, oMOVING, oHIT, oROW, oCOL
  );

  modport master (
    output iDATA_X, iDATA_Y, iDATA_STOP, iCENTER,
    input  oPOS_X, oPOS_Y, oMOVING, oHIT, oROW, oCOL
  );
endinterface

// File: rtl/tilt_cursor_mover_debounce.sv
// Accepts a 4-bit tilt vector only after it has held for STABLE_CYC cycles.
// Latency STABLE_CYC edges from the sampling edge to acc; no backpressure.
module tilt_debounce #(
  parameter int STABLE_CYC = 20000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw,
  output logic [3:0] acc,
  output logic [3:0] acc_nxt
);

  logic [3:0]       cand;
  logic [CNT_W-1:0] stab_cnt;
  logic             stable;

  assign stable = (raw == cand) && (stab_cnt == CNT_W'(STABLE_CYC - 1));

  // acc_nxt lets the step FSM react on the same edge that acc is loaded.
  always_comb begin
    acc_nxt = acc;
    if (stable) acc_nxt = cand;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand     <= '0;
      acc      <= '0;
      stab_cnt <= '0;
    end else begin
      acc <= acc_nxt;
      if (raw != cand) begin
        cand     <= raw;
        stab_cnt <= '0;
      end else if (!stable) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tilt_cursor_mover.sv
// Debounced tilt -> rate-limited, saturating cursor on a row-scanned GRID x GRID LED matrix.
// Steps land on the debounce acceptance edge, then every STEP_CYC; no backpressure.
module tilt_cursor_mover
  import tilt_pkg::*;
#(
  parameter int GRID       = GRID_DEF,
  parameter int PW         = $clog2(GRID),
  parameter int STABLE_CYC = 20000,
  parameter int STEP_CYC   = 400000,
  parameter int SCAN_CYC   = 2000,
  parameter int CNT_W      = 20
) (
  input  logic               iCLK,
  input  logic               iRSTN,
  tilt_cursor_mover_if.slave bus
);

  localparam logic [GRID-1:0] ONE    = GRID'(1);
  localparam logic [PW-1:0]   CENTER = PW'(GRID / 2);
  localparam logic [PW-1:0]   EDGE   = PW'(GRID - 1);

  logic [3:0]       raw;
  logic [3:0]       acc;
  logic [3:0]       acc_nxt;
  logic             xe, xs, ye, ys;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  logic             step;

  logic [PW-1:0]    pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic             x_blk, y_blk;
  logic             hit, hit_nxt;

  logic [CNT_W-1:0] scan_cnt;
  logic [PW-1:0]    row_idx;
  logic [GRID-1:0]  row_drv;
  logic [GRID-1:0]  col_drv;

  assign raw = bus.iDATA_STOP ? 4'b0000
                              : {norm_axis(bus.iDATA_X), norm_axis(bus.iDATA_Y)};

  tilt_debounce #(
    .STABLE_CYC (STABLE_CYC),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .clk     (iCLK),
    .rst_n   (iRSTN),
    .raw     (raw),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

  assign {xe, xs, ye, ys} = acc_nxt;

  // A new nonzero direction counts as re-entry: step now, restart the interval.
  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    step         = 1'b0;
    case (state)
      HOLD: begin
        if (acc_nxt != 4'b0000) begin
          state_nxt    = MOVE;
          step         = 1'b1;
          step_cnt_nxt = '0;
        end
      end
      MOVE: begin
        if (acc_nxt == 4'b0000) begin
          state_nxt    = HOLD;
          step_cnt_nxt = '0;
        end else if (acc_nxt != acc) begin
          step         = 1'b1;
          step_cnt_nxt = '0;
        end else if (step_cnt == CNT_W'(STEP_CYC - 1)) begin
          step         = 1'b1;
          step_cnt_nxt = '0;
        end else begin
          step_cnt_nxt = step_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = HOLD;
        step_cnt_nxt = '0;
      end
    endcase
    if (bus.iCENTER) begin
      step         = 1'b0;
      step_cnt_nxt = '0;
    end
  end

  // Axes saturate independently, so a diagonal can slide along an edge.
  always_comb begin
    x_blk     = xe && (xs ? (pos_x == '0) : (pos_x == EDGE));
    y_blk     = ye && (ys ? (pos_y == '0) : (pos_y == EDGE));
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    hit_nxt   = 1'b0;
    if (step) begin
      if (xe && !x_blk) pos_x_nxt = xs ? pos_x - PW'(1) : pos_x + PW'(1);
      if (ye && !y_blk) pos_y_nxt = ys ? pos_y - PW'(1) : pos_y + PW'(1);
      hit_nxt = x_blk || y_blk;
    end
    if (bus.iCENTER) begin
      pos_x_nxt = CENTER;
      pos_y_nxt = CENTER;
      hit_nxt   = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      state    <= HOLD;
      step_cnt <= '0;
      pos_x    <= CENTER;
      pos_y    <= CENTER;
      hit      <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      hit      <= hit_nxt;
    end
  end

  // Drives are loaded only at the start of a row, so a row never tears mid-scan.
  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      scan_cnt <= '0;
      row_idx  <= '0;
      row_drv  <= '1;
      col_drv  <= '0;
    end else begin
      if (scan_cnt == CNT_W'(SCAN_CYC - 1)) begin
        scan_cnt <= '0;
        row_idx  <= row_idx + PW'(1);
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
      if (scan_cnt == '0) begin
        row_drv <= ~(ONE << row_idx);
        col_drv <= (row_idx == pos_y) ? (ONE << pos_x) : '0;
      end
    end
  end

  assign bus.oPOS_X  = pos_x;
  assign bus.oPOS_Y  = pos_y;
  assign bus.oMOVING = (state == MOVE);
  assign bus.oHIT    = hit;
  assign bus.oROW    = row_drv;
  assign bus.oCOL    = col_drv;

endmodule

// File: tb/tb_tilt_cursor_mover.sv
// Directed bench for tilt_cursor_mover with small timing parameters and a queue scoreboard.
module tb_tilt_cursor_mover;
  import tilt_pkg::*;

  localparam int GRID = 8;
  localparam int PW   = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tilt_cursor_mover_if #(.GRID(GRID), .PW(PW)) bus ();

  tilt_cursor_mover #(
    .GRID       (GRID),
    .PW         (PW),
    .STABLE_CYC (4),
    .STEP_CYC   (10),
    .SCAN_CYC   (2),
    .CNT_W      (20)
  ) dut (
    .iCLK  (clk),
    .iRSTN (rstn),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] mov;
    logic [7:0] hit;
  } pos_exp_t;

  typedef struct {
    string      tag;
    logic [7:0] row;
    logic [7:0] col;
  } scan_exp_t;

  pos_exp_t  pos_q[$];
  scan_exp_t scan_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      ecnt++;
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] x, input logic [1:0] y, input logic stop, input logic ctr);
    bus.iDATA_X    = x;
    bus.iDATA_Y    = y;
    bus.iDATA_STOP = stop;
    bus.iCENTER    = ctr;
  endtask

  task automatic push_pos(input string tag, input int x, input int y, input bit mov, input bit hit);
    pos_exp_t e;
    e.tag = tag;
    e.x   = 8'(x);
    e.y   = 8'(y);
    e.mov = {7'd0, mov};
    e.hit = {7'd0, hit};
    pos_q.push_back(e);
  endtask

  task automatic check_pos();
    pos_exp_t e;
    e = pos_q.pop_front();
    cmp({e.tag, ".x"},   {5'd0, bus.oPOS_X},  e.x);
    cmp({e.tag, ".y"},   {5'd0, bus.oPOS_Y},  e.y);
    cmp({e.tag, ".mov"}, {7'd0, bus.oMOVING}, e.mov);
    cmp({e.tag, ".hit"}, {7'd0, bus.oHIT},    e.hit);
  endtask

  task automatic push_scan(input string tag, input int row_idx, input logic [7:0] col);
    scan_exp_t e;
    logic [7:0] one;
    one   = 8'h01;
    e.tag = tag;
    e.row = ~(one << row_idx);
    e.col = col;
    scan_q.push_back(e);
  endtask

  task automatic check_scan();
    scan_exp_t e;
    e = scan_q.pop_front();
    cmp({e.tag, ".row"}, bus.oROW, e.row);
    cmp({e.tag, ".col"}, bus.oCOL, e.col);
  endtask

  initial begin
    drive(TILT_NONE, TILT_NONE, 1'b0, 1'b0);
    rstn = 1'b0;
    tick(3);
    push_pos("reset", 4, 4, 0, 0); check_pos();
    cmp("reset.row", bus.oROW, 8'hFF);
    cmp("reset.col", bus.oCOL, 8'h00);

    // +X until the right edge
    rstn = 1'b1;
    drive(TILT_POS, TILT_NONE, 1'b0, 1'b0);
    push_pos("t1_wait", 4, 4, 0, 0); tick(4); check_pos();
    push_pos("t1_s1",   5, 4, 1, 0); tick(1); check_pos();
    push_pos("t1_gap",  5, 4, 1, 0); tick(9); check_pos();
    push_pos("t1_s2",   6, 4, 1, 0); tick(1); check_pos();
    push_pos("t1_s3",   7, 4, 1, 0); tick(10); check_pos();
    push_pos("t1_edge", 7, 4, 1, 1); tick(10); check_pos();
    push_pos("t1_hit1", 7, 4, 1, 0); tick(1); check_pos();

    // reset mid-step, then a glitch shorter than the debounce window
    rstn = 1'b0;
    drive(TILT_NONE, TILT_NONE, 1'b0, 1'b0);
    push_pos("t2_rst", 4, 4, 0, 0); tick(2); check_pos();
    rstn = 1'b1;
    drive(TILT_POS, TILT_NONE, 1'b0, 1'b0);
    tick(3);
    drive(TILT_NONE, TILT_NONE, 1'b0, 1'b0);
    push_pos("t2_glitch", 4, 4, 0, 0); tick(6); check_pos();

    // diagonal -X +Y into the corner
    drive(TILT_NEG, TILT_POS, 1'b0, 1'b0);
    push_pos("t3_wait", 4, 4, 0, 0); tick(4); check_pos();
    push_pos("t3_s1", 3, 5, 1, 0); tick(1); check_pos();
    push_pos("t3_s2", 2, 6, 1, 0); tick(10); check_pos();
    push_pos("t3_s3", 1, 7, 1, 0); tick(10); check_pos();
    push_pos("t3_s4", 0, 7, 1, 1); tick(10); check_pos();
    push_pos("t3_s5", 0, 7, 1, 1); tick(10); check_pos();

    // STOP overrides a tilt, then release
    drive(TILT_POS, TILT_NEG, 1'b1, 1'b0);
    push_pos("t4_stop_wait", 0, 7, 1, 0); tick(4); check_pos();
    push_pos("t4_stop_hold", 0, 7, 0, 0); tick(1); check_pos();
    push_pos("t4_stop_idle", 0, 7, 0, 0); tick(10); check_pos();
    drive(TILT_POS, TILT_NEG, 1'b0, 1'b0);
    push_pos("t4_rel_wait", 0, 7, 0, 0); tick(4); check_pos();
    push_pos("t4_rel_step", 1, 6, 1, 0); tick(1); check_pos();

    // walk to (7,0), then centre on a step edge and mid-interval
    for (int i = 1; i <= 6; i++) begin
      push_pos($sformatf("t5_walk%0d", i), 1 + i, 6 - i, 1, 0);
      tick(10);
      check_pos();
    end
    push_pos("t5_pre", 7, 0, 1, 0); tick(9); check_pos();
    drive(TILT_POS, TILT_NEG, 1'b0, 1'b1);
    push_pos("t5_ctr_edge", 4, 4, 1, 0); tick(1); check_pos();
    drive(TILT_POS, TILT_NEG, 1'b0, 1'b0);
    push_pos("t5_ctr_gap", 4, 4, 1, 0); tick(9); check_pos();
    push_pos("t5_ctr_step", 5, 3, 1, 0); tick(1); check_pos();
    tick(4);
    drive(TILT_POS, TILT_NEG, 1'b0, 1'b1);
    push_pos("t5_ctr_mid", 4, 4, 1, 0); tick(1); check_pos();
    drive(TILT_POS, TILT_NEG, 1'b0, 1'b0);
    push_pos("t5_mid_gap", 4, 4, 1, 0); tick(9); check_pos();
    push_pos("t5_mid_step", 5, 3, 1, 0); tick(1); check_pos();

    // reset, scan start, re-entry to reach (2,5)
    rstn = 1'b0;
    drive(TILT_NONE, TILT_NONE, 1'b0, 1'b0);
    tick(2);
    cmp("t6_rst.row", bus.oROW, 8'hFF);
    rstn = 1'b1;
    ecnt = 0;
    drive(TILT_NEG, TILT_POS, 1'b0, 1'b0);
    tick(1);
    cmp("t6_first.row", bus.oROW, 8'hFE);
    cmp("t6_first.col", bus.oCOL, 8'h00);
    tick(1);
    cmp("t6_second.row", bus.oROW, 8'hFE);
    tick(1);
    cmp("t6_third.row", bus.oROW, 8'hFD);
    push_pos("t6_s1", 3, 5, 1, 0); tick(2); check_pos();
    drive(TILT_NEG, TILT_NONE, 1'b0, 1'b0);
    push_pos("t6_re_wait", 3, 5, 1, 0); tick(4); check_pos();
    push_pos("t6_reentry", 2, 5, 1, 0); tick(1); check_pos();
    drive(TILT_NEG, TILT_NONE, 1'b1, 1'b0);
    push_pos("t6_parked", 2, 5, 0, 0); tick(5); check_pos();

    // scan with pos (2,5): row shown after release edge n is ((n-1)/2) mod 8
    for (int i = 0; i < 32; i++) begin
      int r;
      r = ((ecnt + 1 - 1) / 2) % GRID;
      push_scan($sformatf("scan%0d", i), r, (r == 5) ? 8'h04 : 8'h00);
      tick(1);
      check_scan();
    end

    rstn = 1'b0;
    tick(1);
    cmp("t6_midscan_rst.row", bus.oROW, 8'hFF);
    cmp("t6_midscan_rst.col", bus.oCOL, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
